// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// overflow/underflow pulses and optional first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       r_en,
    output logic [DATA_W-1:0]          data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              wr_acc;
    logic              rd_acc;

    assign empty        = (cnt == '0);
    assign full         = (cnt == DEPTH_C);
    assign almost_full  = (cnt >= AF_C);
    assign almost_empty = (cnt <= AE_C);
    assign count        = cnt;

    // A pop at full frees the slot the concurrent push lands in.
    assign rd_acc = r_en && !empty;
    assign wr_acc = w_en && (!full || rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            overflow  <= w_en && !wr_acc;
            underflow <= r_en && !rd_acc;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign data_out = mem[rd_ptr];
        end else begin : g_std
            logic [DATA_W-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (rd_acc) begin
                    rd_q <= mem[rd_ptr];
                end
            end
            assign data_out = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: registered-read and FWFT instances,
// queue scoreboard for ordering, inline comparisons per scenario.
module tb_sync_fifo_param;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst, w_en, r_en;
    logic [7:0] data_in, data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       rst1, w1, r1;
    logic [7:0] d1, q1;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0] count1;

    int checks = 0;
    int errors = 0;
    int mcount = 0;
    logic [7:0] mlast = 8'h00;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(1'b0)) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(1'b1)) dut_fwft (
        .clk(clk), .rst(rst1), .w_en(w1), .data_in(d1), .r_en(r1),
        .data_out(q1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1),
        .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    // Model update and one clock of stimulus on the registered-read FIFO.
    task automatic drive(input logic w, input logic [7:0] d, input logic r,
                         output logic [7:0] exp);
        logic rd, wa;
        rd = r && (mcount != 0);
        wa = w && ((mcount != DEPTH) || rd);
        if (rd) mlast = sb.pop_front();
        if (wa) sb.push_back(d);
        mcount = mcount + int'(wa) - int'(rd);
        exp = mlast;
        w_en = w; data_in = d; r_en = r;
        @(posedge clk); #1;
        w_en = 1'b0; r_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete(); mcount = 0; mlast = 8'h00;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL rst_ae: got %b want 1", almost_empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_af: got %b want 0", almost_full); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h want 00", data_out); end
    endtask

    task automatic test_single();
        logic [7:0] e;
        drive(1'b1, 8'hFA, 1'b0, e);
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_cnt1: got %0d want 1", count); end
        drive(1'b0, 8'h00, 1'b1, e);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_cnt0: got %0d want 0", count); end
        checks++; if (data_out !== 8'hFA || e !== 8'hFA) begin errors++; $display("FAIL single_dout: got %h want FA", data_out); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", empty); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] e;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 8'(i), 1'b0, e);
            checks++; if (count !== 5'(mcount)) begin errors++; $display("FAIL fill_cnt: got %0d want %0d", count, mcount); end
            checks++; if (almost_full !== (mcount >= 14)) begin errors++; $display("FAIL fill_af at %0d: got %b", mcount, almost_full); end
            checks++; if (full !== (mcount == 16)) begin errors++; $display("FAIL fill_full at %0d: got %b", mcount, full); end
        end
        drive(1'b1, 8'hEE, 1'b0, e);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_cnt: got %0d want 16", count); end
        drive(1'b0, 8'h00, 1'b0, e);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 8'h00, 1'b1, e);
            checks++; if (data_out !== e) begin errors++; $display("FAIL drain_data: got %h want %h", data_out, e); end
        end
        drive(1'b0, 8'h00, 1'b1, e);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_pulse: got %b want 1", underflow); end
        checks++; if (data_out !== 8'h0F) begin errors++; $display("FAIL unf_hold: got %h want 0F", data_out); end
        drive(1'b0, 8'h00, 1'b0, e);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b want 0", underflow); end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        for (int blk = 0; blk < 2; blk++) begin
            for (int i = 0; i < 10; i++) drive(1'b1, 8'(8'h10 * (blk + 1) + i), 1'b0, e);
            checks++; if (count !== 5'd10) begin errors++; $display("FAIL wrap_peak: got %0d want 10", count); end
            for (int i = 0; i < 10; i++) begin
                drive(1'b0, 8'h00, 1'b1, e);
                checks++; if (data_out !== e) begin errors++; $display("FAIL wrap_data: got %h want %h", data_out, e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        drive(1'b1, 8'h50, 1'b0, e);
        for (int i = 1; i < 6; i++) begin
            drive(1'b1, 8'(8'h50 + i), 1'b1, e);
            checks++; if (data_out !== e || count !== 5'd1) begin errors++; $display("FAIL b2b: got %h/%0d want %h/1", data_out, count, e); end
        end
        drive(1'b0, 8'h00, 1'b1, e);
    endtask

    task automatic test_simultaneous();
        logic [7:0] e;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, e);
        drive(1'b1, 8'h77, 1'b1, e);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL sim_full_cnt: got %0d want 16", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sim_full_ovf: got %b want 0", overflow); end
        checks++; if (data_out !== 8'h60 || e !== 8'h60) begin errors++; $display("FAIL sim_full_data: got %h want 60", data_out); end
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 8'h00, 1'b1, e);
            checks++; if (data_out !== e) begin errors++; $display("FAIL sim_drain: got %h want %h", data_out, e); end
        end
        drive(1'b1, 8'h88, 1'b1, e);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL sim_empty_unf: got %b want 1", underflow); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL sim_empty_cnt: got %0d want 1", count); end
        drive(1'b0, 8'h00, 1'b1, e);
        checks++; if (data_out !== 8'h88) begin errors++; $display("FAIL sim_empty_data: got %h want 88", data_out); end
    endtask

    task automatic test_fwft();
        w1 = 1'b1; d1 = 8'hA5;
        @(posedge clk); #1;
        w1 = 1'b0;
        checks++; if (q1 !== 8'hA5) begin errors++; $display("FAIL fwft_head: got %h want A5", q1); end
        checks++; if (count1 !== 5'd1) begin errors++; $display("FAIL fwft_cnt: got %0d want 1", count1); end
        r1 = 1'b1;
        @(posedge clk); #1;
        r1 = 1'b0;
        checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL fwft_pop: got %b want 1", empty1); end
        for (int i = 0; i < 5; i++) begin
            w1 = 1'b1; d1 = 8'(8'hB0 + i);
            @(posedge clk); #1;
        end
        w1 = 1'b0;
        checks++; if (q1 !== 8'hB0 || count1 !== 5'd5) begin errors++; $display("FAIL fwft_load: got %h/%0d want B0/5", q1, count1); end
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        checks++; if (count1 !== 5'd0) begin errors++; $display("FAIL fwft_rst_cnt: got %0d want 0", count1); end
        checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL fwft_rst_empty: got %b want 1", empty1); end
    endtask

    initial begin
        rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = 8'h00;
        rst1 = 1'b1; w1 = 1'b0; r1 = 1'b0; d1 = 8'h00;
        test_reset();
        rst1 = 1'b0;
        test_single();
        test_fill_drain();
        test_wrap();
        test_back_to_back();
        test_simultaneous();
        test_fwft();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
